boot_word_loader: RTL and testbench
===================================

Name: boot_word_loader

Overview:
- Boot-time programming stage that sits directly downstream of the UART programming receiver and SPI byte sources, and directly upstream of the instruction memory write port.
- Consumes a byte stream (rx_dv/rx_byte) and assembles bytes into little-endian 32-bit words.
- Writes each word to consecutive ICCM word addresses.
- Holds the system in reset until an end-of-program marker word arrives, then releases it.

Parameters:
- ADDR_W, 14, ICCM word-address width (12-bit index plus 2-bit extension).
- END_WORD, 32'h0000_0FFF, end-of-program marker; never written to memory.
- TIMEOUT_CYC, 16'd50000, idle cycles after which a partially assembled word is discarded.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- rx_dv_i  in  1  byte-valid strobe; one cycle per byte.
- rx_byte_i  in  8  received byte, valid when rx_dv_i=1.
- we_o  out  1  ICCM write enable, single-cycle pulse.
- addr_o  out  ADDR_W  ICCM word address for the current write.
- wdata_o  out  32  assembled word.
- hold_rst_o  out  1  system reset request; 1 while programming.
- done_o  out  1  sticky; end marker received or address space exhausted.
- err_o  out  1  sticky; a word arrived after the last address was written.
- word_cnt_o  out  ADDR_W+1  number of words written.

Behaviour:
- Reset: asynchronous, active-high, one clock.
  - Reset values: we_o=0, addr_o=0, wdata_o=0, hold_rst_o=1, done_o=0, err_o=0, word_cnt_o=0.
  - Internal state: byte_cnt=0, state=COLLECT, timeout counter=0.
  - Asserting rst_i mid-word discards partial bytes and returns addr to 0.
- States: COLLECT, WRITE, DONE.
- COLLECT:
  - On rx_dv_i, shift rx_byte_i into byte lane byte_cnt (first byte lands in [7:0], fourth in [31:24]); byte_cnt increments.
  - When the 4th byte is accepted, byte_cnt wraps to 0 and the assembled word is checked:
    - word==END_WORD: go to DONE; no write; hold_rst_o drops on the next edge.
    - word_cnt_o==2**ADDR_W (memory full): set err_o and done_o, go to DONE; no write.
    - Otherwise: register wdata_o and go to WRITE.
- WRITE (exactly 1 cycle):
  - we_o=1 with addr_o and wdata_o stable.
  - Next edge: addr_o+1 (wraps 0 only when full, which then blocks further writes), word_cnt_o+1, back to COLLECT.
- Latency: we_o asserts on the cycle after the edge that captured the 4th byte.
- An rx_dv_i arriving in the WRITE cycle is accepted as byte 0 of the next word; back-to-back strobes every cycle must lose no byte.
- DONE:
  - Terminal until rst_i; all rx_dv_i ignored.
  - Outputs: we_o=0, hold_rst_o=0, done_o=1.
- Timeout:
  - The counter runs in COLLECT while byte_cnt!=0 and clears on every rx_dv_i.
  - On reaching TIMEOUT_CYC, byte_cnt is cleared and the partial word dropped. No error, no write.
  - The counter is inactive when byte_cnt==0.
- Invariants:
  - we_o is never high while hold_rst_o==0.
  - addr_o changes only on the edge ending WRITE.
  - wdata_o holds its last value outside WRITE.

Test Plan:
- Bytes 78 56 34 12 then FF 0F 00 00 → one we_o pulse with addr_o=0 and wdata_o=32'h12345678; word_cnt_o=1; hold_rst_o 1→0 one cycle after the last marker byte; done_o=1, err_o=0.
- Three words on back-to-back rx_dv_i (12 consecutive cycles) → three we_o pulses at addr 0, 1, 2 with the correct data; no byte lost across WRITE cycles.
- Bytes AA BB, then silence for TIMEOUT_CYC cycles, then 01 02 03 04 → single write of 32'h04030201 at addr 0; AA and BB are discarded; err_o=0.
- ADDR_W=2 build, 5 words (none END_WORD) → writes at addr 0–3, 5th word not written; err_o=1, done_o=1, hold_rst_o=0, word_cnt_o=4.
- rst_i pulsed after 2 bytes of word 1 (addr_o=1) → all outputs return to reset values; next full word writes at addr 0.
- In DONE, 8 further bytes → no we_o, outputs unchanged.

Source files
------------

// File: rtl/boot_word_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words, writes them to
// consecutive ICCM addresses and holds the system in reset until the end-of-program marker.
module boot_word_loader #(
    parameter int unsigned ADDR_W      = 14,
    parameter logic [31:0] END_WORD    = 32'h0000_0FFF,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              hold_rst_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              err_q, err_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [31:0]       word_next;

    // State register; the partial word buffer is reset too so a reset mid-word leaves no residue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= COLLECT;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            wdata_q    <= 32'd0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            tmo_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        tmo_d      = tmo_q;

        // Word as it would look with the incoming byte dropped into its lane.
        word_next = asm_q;
        word_next[{byte_cnt_q, 3'b000} +: 8] = rx_byte_i;

        unique case (state_q)
            COLLECT: begin
                if (rx_dv_i) begin
                    tmo_d = 16'd0;
                    asm_d = word_next;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        if (word_next == END_WORD) begin
                            state_d = DONE;
                        end else if (word_cnt_q == FULL_CNT) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            wdata_d = word_next;
                            state_d = WRITE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (byte_cnt_q != 2'd0) begin
                    // A stalled sender leaves a partial word; drop it after the idle window.
                    if (tmo_q + 16'd1 == TIMEOUT_CYC) begin
                        byte_cnt_d = 2'd0;
                        tmo_d      = 16'd0;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            WRITE: begin
                addr_d     = addr_q + ADDR_ONE;
                word_cnt_d = word_cnt_q + CNT_ONE;
                state_d    = COLLECT;
                // byte_cnt is always 0 here, so a strobe this cycle starts the next word.
                if (rx_dv_i) begin
                    asm_d      = word_next;
                    byte_cnt_d = 2'd1;
                    tmo_d      = 16'd0;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    assign we_o       = (state_q == WRITE);
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign hold_rst_o = (state_q != DONE);
    assign done_o     = (state_q == DONE);
    assign err_o      = err_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_boot_word_loader.sv
// Directed bench for boot_word_loader: a full-size instance (short timeout) and a 4-word instance.
module tb_boot_word_loader;

    localparam logic [15:0] TMO = 16'd40;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, dv_a, dv_b;
    logic [7:0]  rx_byte;

    logic        we_a, hold_a, done_a, err_a;
    logic [13:0] addr_a;
    logic [31:0] wdata_a;
    logic [14:0] cnt_a;

    logic        we_b, hold_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    int          la_addr[$];
    logic [31:0] la_data[$];
    int          lb_addr[$];
    logic [31:0] lb_data[$];
    logic [31:0] stim_q[$];

    always #5 clk = ~clk;

    boot_word_loader #(.ADDR_W(14), .END_WORD(32'h0000_0FFF), .TIMEOUT_CYC(TMO)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .rx_dv_i(dv_a), .rx_byte_i(rx_byte),
        .we_o(we_a), .addr_o(addr_a), .wdata_o(wdata_a), .hold_rst_o(hold_a),
        .done_o(done_a), .err_o(err_a), .word_cnt_o(cnt_a)
    );

    boot_word_loader #(.ADDR_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .rx_dv_i(dv_b), .rx_byte_i(rx_byte),
        .we_o(we_b), .addr_o(addr_b), .wdata_o(wdata_b), .hold_rst_o(hold_b),
        .done_o(done_b), .err_o(err_b), .word_cnt_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write log, sampled on the falling edge.
    always @(negedge clk) begin
        if (we_a) begin
            la_addr.push_back(int'(addr_a));
            la_data.push_back(wdata_a);
            check("a_we_while_hold", hold_a, 1);
        end
        if (we_b) begin
            lb_addr.push_back(int'(addr_b));
            lb_data.push_back(wdata_b);
            check("b_we_while_hold", hold_b, 1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input bit to_b, input logic [7:0] b);
        @(negedge clk);
        if (to_b) dv_b = 1'b1; else dv_a = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv_a = 1'b0;
        dv_b = 1'b0;
    endtask

    task automatic send_stream(input bit to_b);
        logic [31:0] w;
        foreach (stim_q[i]) begin
            w = stim_q[i];
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (to_b) dv_b = 1'b1; else dv_a = 1'b1;
                rx_byte = w[8*k +: 8];
            end
        end
        @(negedge clk);
        dv_a = 1'b0;
        dv_b = 1'b0;
    endtask

    task automatic pulse_rst_a();
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_we"},   we_a,    0);
        check({tag, "_addr"}, addr_a,  0);
        check({tag, "_wd"},   wdata_a, 0);
        check({tag, "_hold"}, hold_a,  1);
        check({tag, "_done"}, done_a,  0);
        check({tag, "_err"},  err_a,   0);
        check({tag, "_cnt"},  cnt_a,   0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; dv_a = 1'b0; dv_b = 1'b0; rx_byte = 8'h00;
        idle(2);
        rst_a = 1'b0; rst_b = 1'b0;
        idle(1);
        check_reset_a("rst");
        check("rst_b_hold", hold_b, 1);
        check("rst_b_cnt",  cnt_b,  0);

        // Single word then end marker
        send_byte(0, 8'h78); send_byte(0, 8'h56); send_byte(0, 8'h34); send_byte(0, 8'h12);
        check("t1_we_lat", we_a,    1);
        check("t1_addr",   addr_a,  0);
        check("t1_wdata",  wdata_a, 32'h1234_5678);
        send_byte(0, 8'hFF); send_byte(0, 8'h0F); send_byte(0, 8'h00);
        check("t1_hold_pre", hold_a, 1);
        send_byte(0, 8'h00);
        check("t1_hold_post", hold_a, 0);
        check("t1_done", done_a, 1);
        check("t1_err",  err_a,  0);
        check("t1_cnt",  cnt_a,  1);
        check("t1_nwr",  la_data.size(), 1);
        if (la_data.size() >= 1) begin
            check("t1_log_addr", la_addr[0], 0);
            check("t1_log_data", la_data[0], 32'h1234_5678);
        end

        // DONE ignores further bytes
        for (int i = 0; i < 8; i++) send_byte(0, 8'(8'h10 + i));
        idle(2);
        check("t6_nwr",  la_data.size(), 1);
        check("t6_done", done_a, 1);
        check("t6_hold", hold_a, 0);
        check("t6_cnt",  cnt_a,  1);
        check("t6_wd",   wdata_a, 32'h1234_5678);
        check("t6_addr", addr_a, 1);

        // Three words back to back
        pulse_rst_a();
        la_addr.delete(); la_data.delete();
        stim_q = '{32'h4433_2211, 32'h8877_6655, 32'hCCBB_AA99};
        send_stream(0);
        idle(3);
        check("t2_nwr", la_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < la_data.size()) begin
                check($sformatf("t2_addr%0d", i), la_addr[i], i);
                check($sformatf("t2_data%0d", i), la_data[i], stim_q[i]);
            end
        end
        check("t2_cnt",  cnt_a,   3);
        check("t2_addr", addr_a,  3);
        check("t2_wd",   wdata_a, 32'hCCBB_AA99);

        // Reset mid-word discards partial bytes
        send_byte(0, 8'h11); send_byte(0, 8'h22);
        check("t5_addr_pre", addr_a, 3);
        pulse_rst_a();
        check_reset_a("t5");
        la_addr.delete(); la_data.delete();
        send_byte(0, 8'hEF); send_byte(0, 8'hBE); send_byte(0, 8'hAD); send_byte(0, 8'hDE);
        idle(2);
        check("t5_nwr", la_data.size(), 1);
        if (la_data.size() >= 1) begin
            check("t5_log_addr", la_addr[0], 0);
            check("t5_log_data", la_data[0], 32'hDEAD_BEEF);
        end

        // Timeout drops a stalled partial word; a shorter gap does not
        pulse_rst_a();
        la_addr.delete(); la_data.delete();
        send_byte(0, 8'hAA); send_byte(0, 8'hBB);
        idle(int'(TMO));
        send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03); send_byte(0, 8'h04);
        idle(2);
        check("t3_nwr", la_data.size(), 1);
        if (la_data.size() >= 1) begin
            check("t3_log_addr", la_addr[0], 0);
            check("t3_log_data", la_data[0], 32'h0403_0201);
        end
        check("t3_err", err_a, 0);
        check("t3_cnt", cnt_a, 1);
        send_byte(0, 8'hAA); send_byte(0, 8'hBB);
        idle(int'(TMO) - 2);
        send_byte(0, 8'h33); send_byte(0, 8'h44);
        idle(2);
        check("t3b_nwr", la_data.size(), 2);
        if (la_data.size() >= 2) begin
            check("t3b_log_addr", la_addr[1], 1);
            check("t3b_log_data", la_data[1], 32'h4433_BBAA);
        end

        // Small build: address space exhausted
        stim_q = '{32'hA3A2_A1A0, 32'hB3B2_B1B0, 32'hC3C2_C1C0, 32'hD3D2_D1D0, 32'hE3E2_E1E0};
        send_stream(1);
        idle(3);
        check("t4_nwr", lb_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < lb_data.size()) begin
                check($sformatf("t4_addr%0d", i), lb_addr[i], i);
                check($sformatf("t4_data%0d", i), lb_data[i], stim_q[i]);
            end
        end
        check("t4_err",  err_b,  1);
        check("t4_done", done_b, 1);
        check("t4_hold", hold_b, 0);
        check("t4_cnt",  cnt_b,  4);
        check("t4_addr", addr_b, 0);
        check("t4_we",   we_b,   0);
        check("t4_wd",   wdata_b, 32'hD3D2_D1D0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
